// File: rtl/gate_lane_pkg.sv
// rtl/gate_lane_pkg.sv - gate modes and per-lane width conversion helper
package gate_lane_pkg;

  typedef enum logic [1:0] {
    MODE_NOT  = 2'b00,
    MODE_XOR  = 2'b01,
    MODE_NAND = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  // Widest lane (in or out) the conversion helper supports.
  localparam int CONV_MAX = 64;

  typedef struct packed {
    logic [CONV_MAX-1:0] val;
    logic                trunc;
  } conv_t;

  // Bits below out_w are kept, bits of r at or above in_w never leak in,
  // so NOT/NAND results zero-extend rather than sign-fill.
  function automatic conv_t conv_lane(input logic [CONV_MAX-1:0] r,
                                      input int in_w, input int out_w);
    conv_t res;
    res.val   = '0;
    res.trunc = 1'b0;
    for (int i = 0; i < CONV_MAX; i++) begin
      if (i < in_w) begin
        if (i < out_w) res.val[i] = r[i];
        else           res.trunc  = res.trunc | r[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gate_lane_fifo.sv
// rtl/gate_lane_fifo.sv - DEPTH x W synchronous FIFO with level and held output
module gate_lane_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int LW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [W-1:0]  wr_data_i,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [W-1:0]  rd_data_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  hold_q, hold_d;
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_valid_o = (level_q != '0);
  assign wr_ready_o = (level_q < LW'(DEPTH)) || rd_ready_i;
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = rd_valid_o && rd_ready_i;
  // When empty the port shows the last popped entry rather than a stale slot.
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : hold_q;
  assign level_o    = level_q;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    hold_d   = pop  ? mem_q[rd_ptr_q]   : hold_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/gate_lane_pipe.sv
// rtl/gate_lane_pipe.sv - multi-lane gate evaluator with width conversion and output FIFO
module gate_lane_pipe
  import gate_lane_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IN_W  = 8,
  parameter int OUT_W = 12,
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       in_mode,
  input  logic [LANES-1:0][IN_W-1:0]       in_a,
  input  logic [LANES-1:0][IN_W-1:0]       in_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES-1:0][OUT_W-1:0]      out_data,
  output logic                             out_trunc,
  output logic                             trunc_sticky,
  output logic [$clog2(DEPTH+1)-1:0]       level
);

  localparam int DW = LANES * OUT_W;

  logic [LANES-1:0][OUT_W-1:0] res_data;
  logic [LANES-1:0]            lane_trunc;
  logic [LANES-1:0]            lane_unused;
  logic [DW:0]                 fifo_rd_data;
  logic                        push;
  logic                        trunc_sticky_q, trunc_sticky_d;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IN_W-1:0] r;
    conv_t           conv;

    always_comb begin
      r = in_a[l];
      case (mode_e'(in_mode))
        MODE_NOT:  r = ~in_a[l];
        MODE_XOR:  r = in_a[l] ^ in_b[l];
        MODE_NAND: r = ~(in_a[l] & in_b[l]);
        default:   r = in_a[l];
      endcase
    end

    assign conv           = conv_lane(CONV_MAX'(r), IN_W, OUT_W);
    assign res_data[l]    = conv.val[OUT_W-1:0];
    assign lane_trunc[l]  = conv.trunc;
    assign lane_unused[l] = ^conv.val;
  end

  gate_lane_fifo #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid_i (in_valid),
    .wr_ready_o (in_ready),
    .wr_data_i  ({|lane_trunc, res_data}),
    .rd_valid_o (out_valid),
    .rd_ready_i (out_ready),
    .rd_data_o  (fifo_rd_data),
    .level_o    (level)
  );

  assign push           = in_valid && in_ready;
  assign trunc_sticky_d = trunc_sticky_q | (push & (|lane_trunc));

  always_ff @(posedge clk) begin
    if (!rst_n) trunc_sticky_q <= 1'b0;
    else        trunc_sticky_q <= trunc_sticky_d;
  end

  assign out_data     = fifo_rd_data[DW-1:0];
  assign out_trunc    = fifo_rd_data[DW];
  assign trunc_sticky = trunc_sticky_q;

endmodule

// File: tb/tb_gate_lane_pipe.sv
// tb/tb_gate_lane_pipe.sv - scoreboard bench for gate_lane_pipe (OUT_W=12 and OUT_W=4)
module tb_gate_lane_pipe;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             out_ready;
  logic [1:0]       in_mode;
  logic [3:0][7:0]  in_a;
  logic [3:0][7:0]  in_b;

  logic             a_in_ready, a_out_valid, a_out_trunc, a_sticky;
  logic [3:0][11:0] a_out_data;
  logic [1:0]       a_level;
  logic             b_in_ready, b_out_valid, b_out_trunc, b_sticky;
  logic [3:0][3:0]  b_out_data;
  logic [1:0]       b_level;

  int n_assert = 0;
  int n_fail   = 0;

  logic [48:0] qa[$];
  logic [48:0] qb[$];
  logic [48:0] la, lb;
  logic        sa, sb;

  gate_lane_pipe #(.LANES(4), .IN_W(8), .OUT_W(12), .DEPTH(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .out_trunc(a_out_trunc),
    .trunc_sticky(a_sticky), .level(a_level)
  );

  gate_lane_pipe #(.LANES(4), .IN_W(8), .OUT_W(4), .DEPTH(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_trunc(b_out_trunc),
    .trunc_sticky(b_sticky), .level(b_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit 48 is the trunc flag; data sits in the low 4*ow bits.
  function automatic logic [48:0] model(input logic [1:0] m, input logic [31:0] a,
                                        input logic [31:0] b, input int ow);
    logic [48:0] res;
    logic [7:0]  r, x, y;
    res = '0;
    for (int l = 0; l < 4; l++) begin
      x = a[l*8 +: 8];
      y = b[l*8 +: 8];
      case (m)
        2'b00:   r = ~x;
        2'b01:   r = x ^ y;
        2'b10:   r = ~(x & y);
        default: r = x;
      endcase
      if (ow == 12) begin
        res[l*12 +: 12] = {4'h0, r};
      end else begin
        res[l*4 +: 4] = r[3:0];
        if (r[7:4] != 4'h0) res[48] = 1'b1;
      end
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [48:0] ea, eb, fr;
    logic        exp_ready, acc;
    @(negedge clk);
    exp_ready = (qa.size() < 2) || out_ready;
    chk("a_level", 64'(a_level), 64'(qa.size()));
    chk("b_level", 64'(b_level), 64'(qb.size()));
    chk("a_out_valid", 64'(a_out_valid), 64'(qa.size() != 0));
    chk("b_out_valid", 64'(b_out_valid), 64'(qb.size() != 0));
    chk("a_in_ready", 64'(a_in_ready), 64'(exp_ready));
    chk("b_in_ready", 64'(b_in_ready), 64'(exp_ready));
    chk("a_sticky", 64'(a_sticky), 64'(sa));
    chk("b_sticky", 64'(b_sticky), 64'(sb));
    if (qa.size() == 0) begin
      chk("a_hold_data", 64'(a_out_data), 64'(la[47:0]));
      chk("a_hold_trunc", 64'(a_out_trunc), 64'(la[48]));
    end
    if (qb.size() == 0) begin
      chk("b_hold_data", 64'(b_out_data), 64'(lb[15:0]));
      chk("b_hold_trunc", 64'(b_out_trunc), 64'(lb[48]));
    end
    if (!rst_n) begin
      qa.delete(); qb.delete();
      la = '0; lb = '0; sa = 1'b0; sb = 1'b0;
    end else begin
      ea  = model(in_mode, in_a, in_b, 12);
      eb  = model(in_mode, in_a, in_b, 4);
      acc = in_valid && exp_ready;
      if (qa.size() != 0 && out_ready) begin
        fr = qa.pop_front();
        chk("a_pop_data", 64'(a_out_data), 64'(fr[47:0]));
        chk("a_pop_trunc", 64'(a_out_trunc), 64'(fr[48]));
        la = fr;
      end
      if (qb.size() != 0 && out_ready) begin
        fr = qb.pop_front();
        chk("b_pop_data", 64'(b_out_data), 64'(fr[15:0]));
        chk("b_pop_trunc", 64'(b_out_trunc), 64'(fr[48]));
        lb = fr;
      end
      if (acc) begin
        qa.push_back(ea);
        qb.push_back(eb);
        sa = sa | ea[48];
        sb = sb | eb[48];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    la = '0; lb = '0; sa = 1'b0; sb = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mode = 2'b00; in_a = '0; in_b = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset_level", 64'(a_level), 64'd0);
    chk("reset_data", 64'(a_out_data), 64'd0);
    chk("reset_in_ready", 64'(a_in_ready), 64'd1);

    // XOR beat
    out_ready = 1'b1; in_valid = 1'b1; in_mode = 2'b01;
    in_a = {8'hFF, 8'h0F, 8'hA5, 8'h00};
    in_b = {8'h0F, 8'h0F, 8'h5A, 8'h00};
    tick();
    in_valid = 1'b0;
    chk("xor_literal", 64'(a_out_data), 64'h0F0_000_0FF_000);
    chk("xor_valid", 64'(a_out_valid), 64'd1);
    tick();

    // NOT zero-extends
    in_valid = 1'b1; in_mode = 2'b00; in_a = '0; in_b = '1;
    tick();
    in_valid = 1'b0;
    chk("not_literal", 64'(a_out_data), 64'h0FF_0FF_0FF_0FF);
    tick();

    // PASS with truncation on the narrow DUT, then a clean PASS
    in_valid = 1'b1; in_mode = 2'b11;
    in_a = {8'h13, 8'h02, 8'h05, 8'h0F};
    tick();
    chk("pass_trunc_data", 64'(b_out_data), 64'h325F);
    chk("pass_trunc_flag", 64'(b_out_trunc), 64'd1);
    in_a = {8'h0F, 8'h0F, 8'h0F, 8'h0F};
    tick();
    in_valid = 1'b0;
    chk("pass_clean_flag", 64'(b_out_trunc), 64'd0);
    chk("sticky_held", 64'(b_sticky), 64'd1);
    tick();

    // Stall: three beats offered, two fit; then pass-through on pop
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b01; in_b = '0;
    in_a = {4{8'h11}}; tick();
    in_a = {4{8'h22}}; tick();
    in_a = {4{8'h33}}; tick();
    chk("full_in_ready", 64'(a_in_ready), 64'd0);
    chk("full_level", 64'(a_level), 64'd2);
    out_ready = 1'b1; tick();
    chk("passthru_level", 64'(a_level), 64'd2);
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("drained_level", 64'(a_level), 64'd0);

    // Reset while full with a beat offered
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b10; in_b = {4{8'hF0}};
    in_a = {4{8'h3C}}; tick();
    in_a = {4{8'hC3}}; tick();
    rst_n = 1'b0; in_a = {4{8'h5A}}; tick();
    rst_n = 1'b1;
    chk("rst_full_level", 64'(a_level), 64'd0);
    chk("rst_full_valid", 64'(a_out_valid), 64'd0);
    in_mode = 2'b01; in_a = {4{8'h77}}; in_b = '0; tick();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("post_rst_first", 64'(a_out_data), 64'h077_077_077_077);
    tick(); tick();

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_mode   = 2'($urandom_range(0, 3));
      in_a      = $urandom;
      in_b      = $urandom;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
